// File: rtl/tt_bist_pkg.sv
// Shared types and defaults for the TT pin-bundle BIST (pattern generator + MISR compactor).
// Pure declarations; no timing or flow-control behaviour of its own.
package tt_bist_pkg;

  typedef enum logic [1:0] {
    MODE_LFSR = 2'd0,
    MODE_CNT  = 2'd1,
    MODE_WALK = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] GEN_POLY_DEF = 16'hB400;
  localparam logic [15:0] GEN_SEED_DEF = 16'h0001;
  localparam logic [31:0] SIG_POLY_DEF = 32'h04C11DB7;
  localparam logic [31:0] SIG_SEED_DEF = 32'hFFFFFFFF;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tt_bist_misr.sv
// Multiple-input signature register: shift-left Galois feedback, XOR-in of one word per enable.
// Latency: sig reflects data one cycle after en; load reseeds; no backpressure.
module tt_bist_misr
  import tt_bist_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = SIG_POLY_DEF,
  parameter logic [WIDTH-1:0] SEED  = SIG_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/tt_pin_bist.sv
// Pin-bundle BIST: drives a TT project from a pattern generator and compacts its outputs.
// Latency start->done = 1+RST_CYCLES+PATTERNS*(SETTLE+1); no backpressure, abort/rst cancel a run.
module tt_pin_bist
  import tt_bist_pkg::*;
#(
  parameter int                      IN_W       = 8,
  parameter int                      UIO_W      = 8,
  parameter int                      PATTERNS   = 256,
  parameter int                      SETTLE     = 1,
  parameter int                      RST_CYCLES = 4,
  parameter logic [IN_W+UIO_W-1:0]   GEN_POLY   = GEN_POLY_DEF,
  parameter logic [IN_W+UIO_W-1:0]   GEN_SEED   = GEN_SEED_DEF,
  parameter logic [31:0]             SIG_POLY   = SIG_POLY_DEF,
  parameter logic [31:0]             SIG_SEED   = SIG_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [31:0]      expected,
  output logic [IN_W-1:0]  dut_ui_in,
  output logic [UIO_W-1:0] dut_uio_in,
  output logic             dut_rst_n,
  output logic             dut_ena,
  input  logic [IN_W-1:0]  dut_uo_out,
  input  logic [UIO_W-1:0] dut_uio_out,
  input  logic [UIO_W-1:0] dut_uio_oe,
  output logic             busy,
  output logic             done,
  output logic [31:0]      signature,
  output logic             pass
);

  localparam int GW = IN_W + UIO_W;
  localparam int RW = cnt_w(RST_CYCLES);
  localparam int SW = cnt_w(SETTLE);
  localparam int PW = cnt_w(PATTERNS);
  localparam logic [GW-1:0] LFSR_SEED = (GEN_SEED == '0) ? GW'(1) : GEN_SEED;

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [GW-1:0] gen_q, gen_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SW-1:0] set_cnt_q, set_cnt_d;
  logic [PW-1:0] pat_cnt_q, pat_cnt_d;
  logic          ena_q, ena_d;
  logic          rstn_q, rstn_d;
  logic          pass_q, pass_d;

  logic          start_acc;
  logic          rst_last;
  logic          capture;
  logic          pat_last;
  logic          sig_match;
  logic [GW-1:0] gen_nxt;
  logic [GW-1:0] cap_vec;
  logic [31:0]   sig;

  assign start_acc = (state_q == ST_IDLE) && start && !abort;
  assign rst_last  = (rst_cnt_q == RW'(RST_CYCLES - 1));
  assign capture   = (state_q == ST_RUN) && (set_cnt_q == SW'(SETTLE));
  assign pat_last  = (pat_cnt_q == PW'(PATTERNS - 1));
  assign sig_match = (sig == expected);

  // Only output-enabled uio pins carry meaningful data back from the project.
  assign cap_vec = {dut_uio_out & dut_uio_oe, dut_uo_out};

  always_comb begin
    gen_nxt = gen_q;
    case (mode_q)
      MODE_CNT:  gen_nxt = gen_q + GW'(1);
      MODE_WALK: gen_nxt = {gen_q[GW-2:0], gen_q[GW-1]};
      default:   gen_nxt = {1'b0, gen_q[GW-1:1]} ^ (gen_q[0] ? GEN_POLY : '0);
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort from any active state wins over everything else.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) state_d = ST_RESET;
      end
      ST_RESET: begin
        if (abort)         state_d = ST_IDLE;
        else if (rst_last) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort)                    state_d = ST_IDLE;
        else if (capture && pat_last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy       = (state_q == ST_RESET) || (state_q == ST_RUN);
    done       = (state_q == ST_DONE);
    pass       = (state_q == ST_DONE) ? sig_match : pass_q;
    dut_rst_n  = rstn_q;
    dut_ena    = ena_q;
    dut_ui_in  = '0;
    dut_uio_in = '0;
    if (state_q != ST_IDLE) begin
      dut_ui_in  = gen_q[IN_W-1:0];
      dut_uio_in = gen_q[GW-1 -: UIO_W] & ~dut_uio_oe;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    gen_d     = gen_q;
    rst_cnt_d = rst_cnt_q;
    set_cnt_d = set_cnt_q;
    pat_cnt_d = pat_cnt_q;
    ena_d     = ena_q;
    rstn_d    = rstn_q;
    pass_d    = pass_q;
    if (start_acc) begin
      mode_d    = (mode == 2'd3) ? MODE_LFSR : mode_e'(mode);
      case (mode_d)
        MODE_CNT:  gen_d = '0;
        MODE_WALK: gen_d = GW'(1);
        default:   gen_d = LFSR_SEED;
      endcase
      rst_cnt_d = '0;
      set_cnt_d = '0;
      pat_cnt_d = '0;
      ena_d     = 1'b1;
      rstn_d    = 1'b0;
      pass_d    = 1'b0;
    end else if (abort && (state_q != ST_IDLE)) begin
      rstn_d = 1'b0;
      pass_d = 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          rst_cnt_d = rst_cnt_q + RW'(1);
          if (rst_last) rstn_d = 1'b1;
        end
        ST_RUN: begin
          if (capture) begin
            set_cnt_d = '0;
            pat_cnt_d = pat_cnt_q + PW'(1);
            gen_d     = gen_nxt;
          end else begin
            set_cnt_d = set_cnt_q + SW'(1);
          end
        end
        ST_DONE: pass_d = sig_match;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_LFSR;
      gen_q     <= LFSR_SEED;
      rst_cnt_q <= '0;
      set_cnt_q <= '0;
      pat_cnt_q <= '0;
      ena_q     <= 1'b0;
      rstn_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      gen_q     <= gen_d;
      rst_cnt_q <= rst_cnt_d;
      set_cnt_q <= set_cnt_d;
      pat_cnt_q <= pat_cnt_d;
      ena_q     <= ena_d;
      rstn_q    <= rstn_d;
      pass_q    <= pass_d;
    end
  end

  tt_bist_misr #(
    .WIDTH (32),
    .POLY  (SIG_POLY),
    .SEED  (SIG_SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (start_acc),
    .en   (capture && !abort),
    .data (32'(cap_vec)),
    .sig  (sig)
  );

  assign signature = sig;

endmodule

// File: tb/tb_tt_pin_bist.sv
// Bench for tt_pin_bist: randomized runs against a pass-through project model, scoreboard on done.
module tb_tt_pin_bist;

  localparam int PA = 20, SA = 0, RA = 2;
  localparam int PB = 4,  SB = 2, RB = 3;
  localparam int LAT_A = 1 + RA + PA * (SA + 1);
  localparam int LAT_B = 1 + RB + PB * (SB + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, abort_a, start_b, abort_b;
  logic [1:0]  mode_a, mode_b;
  logic [31:0] exp_a, exp_b;
  logic [7:0]  ui_a, uioin_a, uo_a, uioout_a, oe_a, x_a;
  logic [7:0]  ui_b, uioin_b, uo_b, uioout_b, oe_b;
  logic        rstn_a, ena_a, busy_a, done_a, pass_a;
  logic        rstn_b, ena_b, busy_b, done_b, pass_b;
  logic [31:0] sig_a, sig_b;

  // Pass-through project: uo mirrors ui, uio_out is uio_in with a per-run XOR.
  assign uo_a     = ui_a;
  assign uioout_a = uioin_a ^ x_a;
  assign uo_b     = ui_b;
  assign uioout_b = uioin_b;

  tt_pin_bist #(.PATTERNS(PA), .SETTLE(SA), .RST_CYCLES(RA)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .mode(mode_a), .expected(exp_a),
    .dut_ui_in(ui_a), .dut_uio_in(uioin_a), .dut_rst_n(rstn_a), .dut_ena(ena_a),
    .dut_uo_out(uo_a), .dut_uio_out(uioout_a), .dut_uio_oe(oe_a),
    .busy(busy_a), .done(done_a), .signature(sig_a), .pass(pass_a)
  );

  tt_pin_bist #(.PATTERNS(PB), .SETTLE(SB), .RST_CYCLES(RB)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .mode(mode_b), .expected(exp_b),
    .dut_ui_in(ui_b), .dut_uio_in(uioin_b), .dut_rst_n(rstn_b), .dut_ena(ena_b),
    .dut_uo_out(uo_b), .dut_uio_out(uioout_b), .dut_uio_oe(oe_b),
    .busy(busy_b), .done(done_b), .signature(sig_b), .pass(pass_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] sig;
    logic        pass;
    int          start_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: apply n patterns of the given mode to the pass-through project and fold the captures.
  function automatic logic [31:0] model_sig(input int m, input logic [7:0] oe, input logic [7:0] x,
                                            input int n);
    logic [15:0] g;
    logic [31:0] s;
    logic [7:0]  ui, uin;
    logic [15:0] c;
    int          mm;
    mm = (m == 3) ? 0 : m;
    g  = (mm == 1) ? 16'h0000 : 16'h0001;
    s  = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      ui  = g[7:0];
      uin = g[15:8] & ~oe;
      c   = {(uin ^ x) & oe, ui};
      s   = (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ {16'h0, c};
      if (mm == 1)      g = g + 16'd1;
      else if (mm == 2) g = (g << 1) | (g >> 15);
      else              g = (g >> 1) ^ (g[0] ? 16'hB400 : 16'h0);
    end
    return s;
  endfunction

  // Scoreboard monitor for instance A
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with no run outstanding, expected 0");
      end else begin
        mon_e = sb_q.pop_front();
        chk("run_sig", sig_a, mon_e.sig);
        chk("run_pass", 32'(pass_a), 32'(mon_e.pass));
        chk("run_latency", 32'(cyc - mon_e.start_cyc), 32'(LAT_A));
      end
    end
  end

  // Called at a negedge; returns one negedge after start is sampled.
  task automatic run_a(input int m, input bit good, input bit push, input logic [7:0] oe,
                       input logic [7:0] x);
    exp_t        e;
    logic [31:0] s;
    oe_a   = oe;
    x_a    = x;
    mode_a = 2'(m);
    s      = model_sig(m, oe, x, PA);
    exp_a  = good ? s : (s ^ 32'h1);
    e.sig = s;
    e.pass = good;
    e.start_cyc = cyc;
    if (push) sb_q.push_back(e);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    mode_a  = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done_a(input bit poke);
    for (int k = 0; k < 200; k++) begin
      if (!busy_a) break;
      @(negedge clk);
      start_a = (poke && k == 4);
    end
    start_a = 1'b0;
    chk("run_timeout_busy", 32'(busy_a), 32'h0);
    @(negedge clk);
  endtask

  task automatic wait_run_a();
    for (int k = 0; k < 20 && !(busy_a && rstn_a); k++) @(negedge clk);
    chk("reach_run", 32'(busy_a && rstn_a), 32'h1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ui"},    32'(ui_a),    32'h0);
    chk({tag, "_uio"},   32'(uioin_a), 32'h0);
    chk({tag, "_rstn"},  32'(rstn_a),  32'h0);
    chk({tag, "_ena"},   32'(ena_a),   32'h0);
    chk({tag, "_busy"},  32'(busy_a),  32'h0);
    chk({tag, "_done"},  32'(done_a),  32'h0);
    chk({tag, "_sig"},   sig_a,        32'hFFFFFFFF);
    chk({tag, "_pass"},  32'(pass_a),  32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not reach its end, expected completion");
    $fatal(1);
  end

  logic [7:0]  ui_seq[32];
  logic [7:0]  uio_seq[32];
  int          wi;
  bit          good;
  int          m;
  logic [7:0]  oe_r, x_r;
  logic [31:0] s_b;
  int          rstn_low, done_cnt, lat_b;
  logic [31:0] sig_at_done;
  logic        pass_at_done;

  initial begin
    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; mode_a = 2'd0; exp_a = '0; oe_a = '0; x_a = '0;
    start_b = 1'b0; abort_b = 1'b0; mode_b = 2'd0; exp_b = '0; oe_b = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Walking one with uio_oe=F0: ui 01..80 then 00; uio_in shows only the low nibble.
    run_a(2, 1'b1, 1'b1, 8'hF0, 8'($urandom));
    wi = 0;
    for (int k = 0; k < 100; k++) begin
      if (!busy_a) break;
      if (busy_a && rstn_a && wi < 32) begin
        ui_seq[wi]  = ui_a;
        uio_seq[wi] = uioin_a;
        wi++;
      end
      @(negedge clk);
    end
    @(negedge clk);
    chk("walk_run_len", 32'(wi), 32'(PA));
    for (int k = 0; k < 10; k++)
      chk("walk_ui", 32'(ui_seq[k]), (k < 8) ? (32'h1 << k) : 32'h0);
    for (int k = 8; k < 16; k++)
      chk("walk_uio_masked", 32'(uio_seq[k]), (32'h1 << (k - 8)) & 32'h0F);

    // Random runs, mid-run mode changes and a start pulse while busy.
    for (int r = 0; r < 8; r++) begin
      m    = $urandom_range(0, 3);
      good = 1'($urandom_range(0, 1));
      run_a(m, good, 1'b1, 8'($urandom), 8'($urandom));
      wait_done_a(1'b1);
    end
    run_a(0, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
    wait_done_a(1'b0);
    repeat (3) @(negedge clk);
    chk("pass_held", 32'(pass_a), 32'h1);
    run_a(1, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
    wait_done_a(1'b0);
    repeat (2) @(negedge clk);
    chk("fail_held", 32'(pass_a), 32'h0);

    // Abort during pattern 2: two captures folded, then frozen.
    oe_r = 8'($urandom);
    x_r  = 8'($urandom);
    run_a(0, 1'b1, 1'b0, oe_r, x_r);
    wait_run_a();
    repeat (2) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'h0);
    chk("abort_rstn", 32'(rstn_a), 32'h0);
    chk("abort_pass", 32'(pass_a), 32'h0);
    chk("abort_sig", sig_a, model_sig(0, oe_r, x_r, 2));
    repeat (30) @(negedge clk);
    chk("abort_sig_frozen", sig_a, model_sig(0, oe_r, x_r, 2));

    // Reset mid-run, then a clean rerun must match an uninterrupted run.
    m = $urandom_range(0, 2);
    run_a(m, 1'b1, 1'b0, oe_r, x_r);
    wait_run_a();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midrst");
    rst = 1'b0;
    @(negedge clk);
    run_a(m, 1'b1, 1'b1, oe_r, x_r);
    wait_done_a(1'b0);

    // Instance B: counter mode, RST_CYCLES=3, SETTLE=2, PATTERNS=4.
    s_b    = model_sig(1, 8'h00, 8'h00, PB);
    mode_b = 2'd1;
    exp_b  = s_b;
    rstn_low = 0;
    done_cnt = 0;
    lat_b = 0;
    sig_at_done = '0;
    pass_at_done = 1'b0;
    wi = cyc;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy_b && !rstn_b) rstn_low++;
      if (done_b) begin
        done_cnt++;
        lat_b = cyc - wi;
        sig_at_done = sig_b;
        pass_at_done = pass_b;
      end
      @(negedge clk);
    end
    chk("b_rstn_low_cycles", 32'(rstn_low), 32'(RB));
    chk("b_done_pulses", 32'(done_cnt), 32'h1);
    chk("b_latency", 32'(lat_b), 32'(LAT_B));
    chk("b_sig", sig_at_done, s_b);
    chk("b_pass", 32'(pass_at_done), 32'h1);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
